// File: rtl/biquad_coeff_bank_pkg.sv
// Shared constants for the biquad coefficient bank: section/word layout,
// commit FSM states and address decode helpers.
package coeff_bank_pkg;

    localparam int DW = 18;

    localparam int SEC_BQ0  = 0;
    localparam int SEC_BQ1  = SEC_BQ0 + 1;
    localparam int SEC_GAIN = SEC_BQ1 + 1;
    localparam int NSEC     = SEC_GAIN + 1;

    // Word layout inside one biquad section.
    localparam int TAPS     = 16;
    localparam int F_BASE   = 0;
    localparam int G_BASE   = F_BASE + TAPS;
    localparam int IIR_BASE = G_BASE + TAPS;
    localparam int INC_BASE = IIR_BASE + 4;
    localparam int NWORD    = INC_BASE + 4;

    localparam int NTOT = NSEC * NWORD;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } commit_state_e;

    function automatic logic adr_valid(input logic [7:0] adr);
        return (adr[7:6] < 2'(NSEC)) && (adr[5:0] < 6'(NWORD));
    endfunction

    function automatic logic [6:0] adr_index(input logic [7:0] adr);
        return 7'(adr[7:6]) * 7'(NWORD) + 7'(adr[5:0]);
    endfunction

endpackage

// File: rtl/biquad_coeff_bank_rise_det.sv
// Input sync register followed by a registered rising-edge pulse; the pulse
// is high for one cycle, two edges after the raw level rises.
module coeff_rise_det (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic level_i,
    output logic rise_o
);

    logic sync_q;
    logic prev_q;
    logic rise_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= level_i;
            prev_q <= sync_q;
            rise_q <= sync_q & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/biquad_coeff_bank.sv
// Shadow/active coefficient store for the biquad/gain datapath; a commit copies
// the whole shadow file at once. Define COEFF_BANK_WR_ERR_EN for sticky wr_err_o.
module biquad_coeff_bank
    import coeff_bank_pkg::*;
(
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [7:0]           coeff_adr_i,
    input  logic                 coeff_wr_i,
    input  logic                 coeff_update_i,
    input  logic [DW-1:0]        coeff_dat_i,
    output logic [NTOT*DW-1:0]   coeff_active_o,
    output logic                 commit_done_o,
    output logic [15:0]          commit_count_o
`ifdef COEFF_BANK_WR_ERR_EN
    ,
    output logic                 wr_err_o
`endif
);

    logic [7:0]    adr_q;
    logic [DW-1:0] dat_q;
    logic          wrRise;
    logic          updRise;

    commit_state_e state_q;
    commit_state_e state_d;
    logic          commitEn;

    logic          wrEn;
    logic [6:0]    wrIdx;

    logic [DW-1:0] shadow_q [NTOT];
    logic [DW-1:0] active_q [NTOT];
    logic          commitDone_q;
    logic [15:0]   commitCount_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            adr_q <= '0;
            dat_q <= '0;
        end else begin
            adr_q <= coeff_adr_i;
            dat_q <= coeff_dat_i;
        end
    end

    coeff_rise_det u_wr_rise (
        .clk_i   (aclk),
        .rst_ni  (aresetn),
        .level_i (coeff_wr_i),
        .rise_o  (wrRise)
    );

    coeff_rise_det u_upd_rise (
        .clk_i   (aclk),
        .rst_ni  (aresetn),
        .level_i (coeff_update_i),
        .rise_o  (updRise)
    );

    // The held write level keeps adr_q/dat_q stable while wrRise is high.
    assign wrEn  = wrRise && adr_valid(adr_q);
    assign wrIdx = adr_index(adr_q);

    always_comb begin
        state_d  = state_q;
        commitEn = 1'b0;
        case (state_q)
            IDLE: if (updRise) state_d = PEND;
            PEND: begin
                commitEn = 1'b1;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NTOT; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (wrEn) begin
            for (int i = 0; i < NTOT; i++) begin
                if (wrIdx == 7'(i)) shadow_q[i] <= dat_q;
            end
        end
    end

    // Active file only ever loads as a whole, so the datapath sees one coherent set.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NTOT; i++) begin
                active_q[i] <= '0;
            end
            commitDone_q  <= 1'b0;
            commitCount_q <= '0;
        end else begin
            commitDone_q <= commitEn;
            if (commitEn) begin
                for (int i = 0; i < NTOT; i++) begin
                    active_q[i] <= shadow_q[i];
                end
                commitCount_q <= commitCount_q + 16'd1;
            end
        end
    end

    for (genvar g = 0; g < NTOT; g++) begin : g_active
        assign coeff_active_o[g*DW +: DW] = active_q[g];
    end

    assign commit_done_o  = commitDone_q;
    assign commit_count_o = commitCount_q;

`ifdef COEFF_BANK_WR_ERR_EN
    logic wrErr_q;

    // A dropped write on the commit edge wins over the clear.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wrErr_q <= 1'b0;
        end else if (wrRise && !adr_valid(adr_q)) begin
            wrErr_q <= 1'b1;
        end else if (commitEn) begin
            wrErr_q <= 1'b0;
        end
    end

    assign wr_err_o = wrErr_q;
`endif

endmodule

// File: tb/tb_biquad_coeff_bank.sv
// Self-checking bench for biquad_coeff_bank: transaction-level model plus
// directed vectors with hand-computed expectations.
module tb_biquad_coeff_bank;
    import coeff_bank_pkg::*;

    logic                aclk = 1'b0;
    logic                aresetn = 1'b0;
    logic [7:0]          coeff_adr_i = '0;
    logic                coeff_wr_i = 1'b0;
    logic                coeff_update_i = 1'b0;
    logic [DW-1:0]       coeff_dat_i = '0;
    logic [NTOT*DW-1:0]  coeff_active_o;
    logic                commit_done_o;
    logic [15:0]         commit_count_o;
`ifdef COEFF_BANK_WR_ERR_EN
    logic                wr_err_o;
`endif

    int checkCount = 0;
    int passCount  = 0;

    biquad_coeff_bank dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .coeff_adr_i    (coeff_adr_i),
        .coeff_wr_i     (coeff_wr_i),
        .coeff_update_i (coeff_update_i),
        .coeff_dat_i    (coeff_dat_i),
        .coeff_active_o (coeff_active_o),
        .commit_done_o  (commit_done_o),
        .commit_count_o (commit_count_o)
`ifdef COEFF_BANK_WR_ERR_EN
        ,
        .wr_err_o       (wr_err_o)
`endif
    );

    always #5 aclk = ~aclk;

    // Model: a rise sampled at edge N writes shadow at N+2 and commits at N+3.
    logic [DW-1:0] mShadow [NTOT];
    logic [DW-1:0] mActive [NTOT];
    logic          mDone;
    logic [15:0]   mCount;
    logic [15:0]   countBias = 16'h0000;
    logic          mErr;
    int            cyc;
    int            wrAt;
    int            cmAt;
    logic [7:0]    wrAdr;
    logic [DW-1:0] wrDat;
    logic          prevWr;
    logic          prevUpd;

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NTOT; i++) begin
                mShadow[i] = '0;
                mActive[i] = '0;
            end
            mDone = 1'b0;
            mCount = '0;
            mErr = 1'b0;
            wrAt = -1;
            cmAt = -1;
            prevWr = 1'b0;
            prevUpd = 1'b0;
            cyc = 0;
        end else begin
            int sec;
            int word;
            logic commitNow;
            logic writeNow;
            logic badNow;
            cyc = cyc + 1;
            commitNow = (cmAt == cyc);
            writeNow = (wrAt == cyc);
            mDone = commitNow;
            if (commitNow) begin
                for (int i = 0; i < NTOT; i++) mActive[i] = mShadow[i];
                mCount = mCount + 16'd1;
                cmAt = -1;
            end
            badNow = 1'b0;
            if (writeNow) begin
                sec = int'(wrAdr) / 64;
                word = int'(wrAdr) % 64;
                if (sec < NSEC && word < NWORD) mShadow[sec*NWORD + word] = wrDat;
                else badNow = 1'b1;
                wrAt = -1;
            end
            if (badNow) mErr = 1'b1;
            else if (commitNow) mErr = 1'b0;
            if (coeff_wr_i && !prevWr) begin
                wrAt = cyc + 2;
                wrAdr = coeff_adr_i;
                wrDat = coeff_dat_i;
            end
            if (coeff_update_i && !prevUpd && cmAt < 0) cmAt = cyc + 3;
            prevWr = coeff_wr_i;
            prevUpd = coeff_update_i;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] activeWord(input int s, input int w);
        return coeff_active_o[(s*NWORD + w)*DW +: DW];
    endfunction

    // Compare against the model every cycle; reports the first differing word.
    always @(negedge aclk) begin
        int bad;
        bad = 0;
        for (int i = NTOT - 1; i >= 0; i--) begin
            if (coeff_active_o[i*DW +: DW] !== mActive[i]) bad = i;
        end
        checkOutput($sformatf("model active[%0d]", bad), 32'(coeff_active_o[bad*DW +: DW]), 32'(mActive[bad]));
        checkOutput("model commit_done", 32'(commit_done_o), 32'(mDone));
        checkOutput("model commit_count", 32'(commit_count_o), 32'(16'(mCount + countBias)));
`ifdef COEFF_BANK_WR_ERR_EN
        checkOutput("model wr_err", 32'(wr_err_o), 32'(mErr));
`endif
    end

    task automatic applyStimulus(input logic wr, input logic upd, input logic [7:0] adr, input logic [DW-1:0] dat);
        @(negedge aclk);
        coeff_wr_i = wr;
        coeff_update_i = upd;
        coeff_adr_i = adr;
        coeff_dat_i = dat;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge aclk);
    endtask

    task automatic writeWord(input logic [7:0] adr, input logic [DW-1:0] dat);
        applyStimulus(1'b1, 1'b0, adr, dat);
        waitCycles(32);
        applyStimulus(1'b0, 1'b0, adr, dat);
        waitCycles(3);
    endtask

    task automatic commitAndCheck(input string name, input logic [15:0] expCount);
        applyStimulus(1'b0, 1'b1, 8'h00, '0);
        waitCycles(3);
        checkOutput({name, " done before"}, 32'(commit_done_o), 32'h0);
        waitCycles(1);
        checkOutput({name, " done"}, 32'(commit_done_o), 32'h1);
        checkOutput({name, " count"}, 32'(commit_count_o), 32'(expCount));
        waitCycles(1);
        checkOutput({name, " done after"}, 32'(commit_done_o), 32'h0);
        waitCycles(27);
        applyStimulus(1'b0, 1'b0, 8'h00, '0);
        waitCycles(3);
    endtask

    initial begin
        $display("[TB] start");
        waitCycles(3);
        checkOutput("reset count", 32'(commit_count_o), 32'h0);
        checkOutput("reset done", 32'(commit_done_o), 32'h0);
        checkOutput("reset word(0,5)", 32'(activeWord(0, 5)), 32'h0);
        @(negedge aclk);
        #2 aresetn = 1'b1;
        waitCycles(2);

        writeWord(8'h05, 18'h1ABCD);
        checkOutput("write no active change", 32'(activeWord(0, 5)), 32'h0);

        // Exact latency: still old value after 3 edges, new value after the 4th.
        applyStimulus(1'b0, 1'b1, 8'h00, '0);
        waitCycles(3);
        checkOutput("latency edge3 word(0,5)", 32'(activeWord(0, 5)), 32'h0);
        waitCycles(1);
        checkOutput("latency edge4 word(0,5)", 32'(activeWord(0, 5)), 32'h1ABCD);
        checkOutput("commit1 done", 32'(commit_done_o), 32'h1);
        checkOutput("commit1 count", 32'(commit_count_o), 32'h1);
        waitCycles(1);
        checkOutput("commit1 done after", 32'(commit_done_o), 32'h0);
        waitCycles(27);
        applyStimulus(1'b0, 1'b0, 8'h00, '0);
        waitCycles(3);

        // Write and update together: the commit carries the new word.
        applyStimulus(1'b1, 1'b1, 8'h45, 18'h3FFFF);
        waitCycles(4);
        checkOutput("simul word(1,5)", 32'(activeWord(1, 5)), 32'h3FFFF);
        checkOutput("simul count", 32'(commit_count_o), 32'h2);
        checkOutput("simul keeps word(0,5)", 32'(activeWord(0, 5)), 32'h1ABCD);
        waitCycles(28);
        applyStimulus(1'b0, 1'b0, 8'h00, '0);
        waitCycles(3);
        checkOutput("simul single commit", 32'(commit_count_o), 32'h2);

        writeWord(8'hC0, 18'h12345);
`ifdef COEFF_BANK_WR_ERR_EN
        checkOutput("err after sec3", 32'(wr_err_o), 32'h1);
`endif
        writeWord(8'h28, 18'h2AAAA);
        writeWord(8'hA7, 18'h15555);
        commitAndCheck("commit3", 16'h3);
        checkOutput("word(2,39) boundary", 32'(activeWord(2, 39)), 32'h15555);
        checkOutput("word 40 no alias (1,0)", 32'(activeWord(1, 0)), 32'h0);
        checkOutput("sec3 no alias (0,0)", 32'(activeWord(0, 0)), 32'h0);
`ifdef COEFF_BANK_WR_ERR_EN
        checkOutput("err cleared by commit", 32'(wr_err_o), 32'h0);
`endif

        commitAndCheck("repeat commit", 16'h4);
        checkOutput("repeat keeps word(1,5)", 32'(activeWord(1, 5)), 32'h3FFFF);

        // Reset while the FSM sits in PEND.
        applyStimulus(1'b0, 1'b1, 8'h00, '0);
        waitCycles(3);
        #2 aresetn = 1'b0;
        waitCycles(1);
        checkOutput("midcommit reset count", 32'(commit_count_o), 32'h0);
        checkOutput("midcommit reset done", 32'(commit_done_o), 32'h0);
        checkOutput("midcommit reset word(0,5)", 32'(activeWord(0, 5)), 32'h0);
        applyStimulus(1'b0, 1'b0, 8'h00, '0);
        waitCycles(2);
        #2 aresetn = 1'b1;
        waitCycles(6);
        checkOutput("post reset no pulse", 32'(commit_done_o), 32'h0);
        checkOutput("post reset word(1,5)", 32'(activeWord(1, 5)), 32'h0);

        // Jump the counter to 0xFFFF, then one commit wraps it.
        @(negedge aclk);
        #2 force dut.commitCount_q = 16'hFFFF;
        countBias = 16'hFFFF;
        @(negedge aclk);
        #2 release dut.commitCount_q;
        waitCycles(2);
        checkOutput("preload count", 32'(commit_count_o), 32'hFFFF);
        commitAndCheck("wrap", 16'h0000);

        waitCycles(2);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
